// File: rtl/conv_pkg.sv
// Shared constants, memory-select codes and FSM state encoding for the pooling engine.
package conv_pkg;
  localparam int DATA_W = 20;
  localparam int ADDR_W = 12;
  localparam int IMG_W  = 64;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    FIN   = 3'd4
  } state_t;
endpackage

// File: rtl/pool_addr_gen.sv
// Window/tap counters for 2x2 stride-2 pooling; addresses are combinational from the counters.
// No backpressure: counters advance only on the tap_adv / win_adv strobes from the FSM.
module pool_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = conv_pkg::IMG_W,
  parameter int ADDR_W = conv_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              tap_adv,
  input  logic              win_adv,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              tap_first,
  output logic              tap_last,
  output logic              last_window
);
  localparam int CW = $clog2(IMG_W / 2);
  localparam logic [CW-1:0] O_MAX = CW'(IMG_W / 2 - 1);

  logic [CW-1:0] ox;
  logic [CW-1:0] oy;
  logic [1:0]    tap;

  // tap wraps 3->0 by itself, so a window boundary only has to step ox/oy
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      ox  <= '0;
      oy  <= '0;
      tap <= '0;
    end else begin
      if (tap_adv) tap <= tap + 2'd1;
      if (win_adv) begin
        if (ox == O_MAX) begin
          ox <= '0;
          oy <= oy + CW'(1);
        end else begin
          ox <= ox + CW'(1);
        end
      end
    end
  end

  // IMG_W is a power of two: row {oy,tap[1]}, column {ox,tap[0]} concatenate into base+offset
  assign rd_addr     = ADDR_W'({oy, tap[1], ox, tap[0]});
  assign wr_addr     = ADDR_W'({oy, ox});
  assign tap_first   = (tap == 2'd0);
  assign tap_last    = (tap == 2'd3);
  assign last_window = (ox == O_MAX) && (oy == O_MAX);
endmodule

// File: rtl/maxpool_engine.sv
// 2x2 max-pool of layer 0 into layer 1; 6 cycles per output (4 reads, wait, write). Optional MAXPOOL_RELU_EN.
// No backpressure: memories are assumed always ready; start is ignored unless idle.
module maxpool_engine
  import conv_pkg::*;
#(
  parameter int IMG_W  = conv_pkg::IMG_W,
  parameter int DATA_W = conv_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              cwr,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [DATA_W-1:0] cdata_wr,
  output logic [2:0]        csel
);
  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_READ  = READ;
  localparam logic [2:0] S_WAIT  = WAIT;
  localparam logic [2:0] S_WRITE = WRITE;
  localparam logic [2:0] S_FIN   = FIN;

  logic [2:0]               state;
  logic [2:0]               state_nxt;
  logic signed [DATA_W-1:0] max_q;
  logic                     rd_vld_q;
  logic                     rd_first_q;
  logic                     start_ok;
  logic                     tap_first;
  logic                     tap_last;
  logic                     last_window;
  logic [ADDR_W-1:0]        rd_addr;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_val;

  assign start_ok = (state == S_IDLE) && start;

  pool_addr_gen #(.IMG_W(IMG_W), .ADDR_W(ADDR_W)) u_addr (
    .clk         (clk),
    .reset       (reset),
    .clr         (start_ok),
    .tap_adv     (crd),
    .win_adv     (cwr),
    .rd_addr     (rd_addr),
    .wr_addr     (wr_addr),
    .tap_first   (tap_first),
    .tap_last    (tap_last),
    .last_window (last_window)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_READ;
      S_READ:  if (tap_last) state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = last_window ? S_FIN : S_READ;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read data lands one cycle after crd; the first tap of a window reloads the maximum.
  // Strict '>' keeps the earlier value on ties.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      rd_vld_q   <= 1'b0;
      rd_first_q <= 1'b0;
      max_q      <= '0;
    end else begin
      state      <= state_nxt;
      rd_vld_q   <= crd;
      rd_first_q <= crd && tap_first;
      if (rd_vld_q && (rd_first_q || ($signed(cdata_rd) > max_q)))
        max_q <= $signed(cdata_rd);
    end
  end

`ifdef MAXPOOL_RELU_EN
  assign wr_val = max_q[DATA_W-1] ? '0 : max_q;
`else
  assign wr_val = max_q;
`endif

  assign crd      = (state == S_READ);
  assign cwr      = (state == S_WRITE);
  assign busy     = (state == S_READ) || (state == S_WAIT) || (state == S_WRITE);
  assign done     = (state == S_FIN);
  assign csel     = crd ? CSEL_L0 : (cwr ? CSEL_L1 : CSEL_NONE);
  assign caddr_rd = crd ? rd_addr : '0;
  assign caddr_wr = cwr ? wr_addr : '0;
  assign cdata_wr = cwr ? wr_val : '0;
endmodule

// File: doc/maxpool_engine.md
MAXPOOL_ENGINE -- requirements
Module: maxpool_engine

Interface
REQ-001 SHALL have parameter IMG_W, default 64, meaning input feature-map width and height in pixels (even, power of two).
REQ-002 SHALL have parameter DATA_W, default 20, meaning signed pixel width (4.16 fixed point).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to pool the full layer-0 map.
REQ-006 SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until done.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse after the last write.
REQ-008 SHALL have port crd, output, 1 bit: read strobe to the layer memories.
REQ-009 SHALL have port caddr_rd, output, 12 bits: read address.
REQ-010 SHALL have port cdata_rd, input, DATA_W bits: read data, valid at the rising edge after the crd cycle (1-cycle latency).
REQ-011 SHALL have port cwr, output, 1 bit: write strobe.
REQ-012 SHALL have port caddr_wr, output, 12 bits: write address.
REQ-013 SHALL have port cdata_wr, output, DATA_W bits: write data.
REQ-014 SHALL have port csel, output, 3 bits: memory select; 3'b001 = layer 0, 3'b011 = layer 1, 3'b000 = none.

Function
REQ-015 SHALL use FSM states IDLE, READ, WAIT, WRITE, FIN.
REQ-016 SHALL move IDLE->READ on start; start while busy SHALL be ignored.
REQ-017 In READ, SHALL assert crd with csel=001 for 4 consecutive cycles at base, base+1, base+IMG_W, base+IMG_W+1, where base = 2*oy*IMG_W + 2*ox.
REQ-018 SHALL capture each cdata_rd one cycle after its read and keep a running signed maximum; the first datum of a window SHALL load the maximum unconditionally.
REQ-019 WAIT (1 cycle) SHALL capture the 4th datum; WRITE (1 cycle) SHALL assert cwr, csel=011, caddr_wr = oy*(IMG_W/2)+ox, cdata_wr = window maximum.
REQ-020 Each output SHALL take exactly 6 cycles; the full 64x64 map SHALL take 6144 cycles from the first READ cycle to the last WRITE.
REQ-021 SHALL iterate ox fastest; ox wraps 31->0 and increments oy; after oy=31, ox=31 is written, SHALL go to FIN.
REQ-022 FIN SHALL pulse done for 1 cycle, drop busy, and return to IDLE.
REQ-023 Comparison SHALL be two's-complement signed; ties SHALL keep the earlier value (result-identical).
REQ-024 crd and cwr SHALL never be asserted in the same cycle; csel SHALL be 000 in IDLE and FIN.

Reset
REQ-025 reset SHALL force state IDLE, counters ox=oy=0, window maximum 0, and busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr all 0 at the next rising edge.
REQ-026 reset asserted mid-operation SHALL abort with no further reads or writes; a later start SHALL restart at output 0.
REQ-027 reset SHALL dominate start in the same cycle.

Configuration
REQ-028 Macro MAXPOOL_RELU_EN: when defined, cdata_wr SHALL be max(0, window maximum); when undefined, the signed maximum SHALL be written unchanged.

Structure
REQ-029 Package conv_pkg SHALL hold DATA_W, ADDR_W=12, IMG_W, the csel codes (CSEL_NONE, CSEL_L0, CSEL_L1), and the state enum typedef.
REQ-030 Sub-module pool_addr_gen SHALL hold the ox/oy/tap counters and produce caddr_rd, caddr_wr, and a last_window flag; the FSM and comparator SHALL stay in maxpool_engine.

Verification
REQ-031 Ramp map L0[i]=i, then start -> L1[o] = L0[base+65] for all 1024 outputs; done after 6144+2 cycles.
REQ-032 Window {0xFFFFF, 0x80000, 0x00001, 0xFFFFE} at output 0 -> L1[0]=0x00001.
REQ-033 All-negative window {0xFFFF0, 0xFFFF8, 0xFFFFC, 0xFFFF1} -> L1=0xFFFFC without MAXPOOL_RELU_EN; 0x00000 with it.
REQ-034 reset pulsed at cycle 1000 of a run -> all outputs 0 next edge, no cwr afterwards; restart -> first write to caddr_wr=0.
REQ-035 start re-asserted during busy -> no effect; exactly 1024 cwr pulses and one done pulse.
REQ-036 Assertion check over all runs -> crd and cwr never high together; caddr_wr in 0..1023; csel=011 whenever cwr is high.
